arith_result_stage: RTL and testbench

//  Registered writeback stage directly downstream of the 32-bit Arithmetic unit.
//  - Captures ResultC and the CarryOut/OverFlow/Negative flags, and derives Zero.
//  - Hands each result on through a 2-entry valid/ready skid buffer, so the

---
 rtl/arith_result_stage.sv | 105 ++++++++++
 tb/tb_arith_result_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/arith_result_stage.sv
// Registered writeback stage behind the 32-bit arithmetic unit: captures result and flags
// into a two-entry valid/ready skid buffer and tracks overflow status for status reads.
module arith_result_stage #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   ResultC,
    input  logic               CarryOut,
    input  logic               OverFlow,
    input  logic               Negative,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   OutResult,
    output logic [3:0]         OutFlags,
    input  logic               ClearSticky,
    output logic               StickyOverflow,
    output logic [COUNT_W-1:0] OvfCount
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   main_result, skid_result;
    logic [3:0]         main_flags, skid_flags;
    logic [3:0]         in_flags;
    logic               push, pop;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    // Handshake outputs depend only on the state register, never on inputs.
    assign InReady   = (state != TWO);
    assign OutValid  = (state != EMPTY);
    assign push      = InValid & InReady;
    assign pop       = OutValid & OutReady;
    assign in_flags  = {Negative, (ResultC == '0), CarryOut, OverFlow};
    assign OutResult = main_result;
    assign OutFlags  = main_flags;

    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (push) next_state = ONE;
            ONE: begin
                if (push && !pop)      next_state = TWO;
                else if (!push && pop) next_state = EMPTY;
            end
            TWO:     if (pop) next_state = ONE;
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= EMPTY;
            main_result <= '0;
            main_flags  <= '0;
            skid_result <= '0;
            skid_flags  <= '0;
        end else begin
            state <= next_state;
            case (state)
                EMPTY: if (push) begin
                    main_result <= ResultC;
                    main_flags  <= in_flags;
                end
                ONE: begin
                    // Popping frees the head, so a new entry can bypass the skid slot.
                    if (push && pop) begin
                        main_result <= ResultC;
                        main_flags  <= in_flags;
                    end else if (push) begin
                        skid_result <= ResultC;
                        skid_flags  <= in_flags;
                    end
                end
                TWO: if (pop) begin
                    main_result <= skid_result;
                    main_flags  <= skid_flags;
                end
                default: ;
            endcase
        end
    end

    // A V=1 push in the same cycle as a clear wins: the clear resets, then this event counts.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StickyOverflow <= 1'b0;
            OvfCount       <= '0;
        end else if (push && OverFlow) begin
            StickyOverflow <= 1'b1;
            OvfCount       <= ClearSticky ? COUNT_W'(1) : sat_inc(OvfCount);
        end else if (ClearSticky) begin
            StickyOverflow <= 1'b0;
            OvfCount       <= '0;
        end
    end

endmodule

// File: tb/tb_arith_result_stage.sv
// Directed bench for arith_result_stage: handshake order, flags, overflow status,
// counter saturation (narrow-counter instance) and mid-operation reset.
module tb_arith_result_stage;

    logic        Clk = 1'b0;
    logic        Reset, InValid, CarryOut, OverFlow, Negative, OutReady, ClearSticky;
    logic [31:0] ResultC;
    logic        InReady, OutValid, StickyOverflow;
    logic [31:0] OutResult;
    logic [3:0]  OutFlags;
    logic [7:0]  OvfCount;
    logic        in_ready2, out_valid2, sticky2;
    logic [31:0] out_result2;
    logic [3:0]  out_flags2;
    logic [1:0]  ovf_count2;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    arith_result_stage #(.WIDTH(32), .COUNT_W(8)) u_dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .ResultC(ResultC), .CarryOut(CarryOut), .OverFlow(OverFlow), .Negative(Negative),
        .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult), .OutFlags(OutFlags),
        .ClearSticky(ClearSticky), .StickyOverflow(StickyOverflow), .OvfCount(OvfCount)
    );

    arith_result_stage #(.WIDTH(32), .COUNT_W(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(in_ready2),
        .ResultC(ResultC), .CarryOut(CarryOut), .OverFlow(OverFlow), .Negative(Negative),
        .OutValid(out_valid2), .OutReady(OutReady), .OutResult(out_result2), .OutFlags(out_flags2),
        .ClearSticky(ClearSticky), .StickyOverflow(sticky2), .OvfCount(ovf_count2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic n, input logic c,
                         input logic o);
        InValid  = v;
        ResultC  = r;
        Negative = n;
        CarryOut = c;
        OverFlow = o;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"},  OutValid, 1'b0);
        check({tag, ".ready"},  InReady, 1'b1);
        check({tag, ".result"}, OutResult, 32'h0);
        check({tag, ".flags"},  OutFlags, 4'h0);
        check({tag, ".sticky"}, StickyOverflow, 1'b0);
        check({tag, ".count"},  OvfCount, 8'd0);
    endtask

    initial begin
        Reset = 1'b1; OutReady = 1'b0; ClearSticky = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); step();
        Reset = 1'b0;
        check_idle("reset");

        // 1: zero result with carry
        OutReady = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t1.valid", OutValid, 1'b1);
        check("t1.result", OutResult, 32'h0);
        check("t1.flags", OutFlags, 4'b0110);
        step();
        check("t1.drain", OutValid, 1'b0);

        // 2: backpressure fills both entries, third is held upstream
        OutReady = 1'b0;
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step();
        check("t2.ready1", InReady, 1'b1);
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        step();
        check("t2.ready2", InReady, 1'b0);
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
        step();
        check("t2.full", InReady, 1'b0);
        check("t2.head", OutResult, 32'h11);
        check("t2.hold_valid", OutValid, 1'b1);
        OutReady = 1'b1;
        step();
        check("t2.second", OutResult, 32'h22);
        check("t2.ready_again", InReady, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t2.third", OutResult, 32'h33);
        check("t2.third_valid", OutValid, 1'b1);
        step();
        check("t2.empty", OutValid, 1'b0);

        // 3: full-throughput stream
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h1000 + i, 1'b0, 1'b0, 1'b0);
            check("t3.inready", InReady, 1'b1);
            step();
            check("t3.out", {OutValid, InReady, OutResult}, {1'b1, 1'b1, 32'h1000 + i});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("t3.empty", OutValid, 1'b0);

        // 4: overflow status, clear collides with a V=1 push
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        step();
        check("t4.flags", OutFlags, 4'b1001);
        check("t4.sticky", StickyOverflow, 1'b1);
        check("t4.count", OvfCount, 8'd1);
        ClearSticky = 1'b1;
        drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b1);
        step();
        check("t4.clr_push_sticky", StickyOverflow, 1'b1);
        check("t4.clr_push_count", OvfCount, 8'd1);
        check("t4.clr_push_flags", OutFlags, 4'b0001);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        ClearSticky = 1'b0;
        check("t4.clr_sticky", StickyOverflow, 1'b0);
        check("t4.clr_count", OvfCount, 8'd0);
        check("t4.clr_count2", ovf_count2, 2'd0);

        // 5: narrow counter saturates, wide one keeps counting
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h40 + i, 1'b0, 1'b0, 1'b1);
            step();
            check("t5.count2", ovf_count2, (i < 3) ? 2'(i + 1) : 2'd3);
            check("t5.count8", OvfCount, 8'(i + 1));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("t5.hold2", ovf_count2, 2'd3);
        check("t5.sticky2", sticky2, 1'b1);

        // 6: reset while full drops both entries; transfer in the reset cycle is ignored
        OutReady = 1'b0;
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
        step();
        check("t6.full", InReady, 1'b0);
        Reset = 1'b1;
        OutReady = 1'b1;
        drive(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1);
        step();
        Reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_idle("t6.reset");
        check("t6.count2", ovf_count2, 2'd0);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t6.fresh_valid", OutValid, 1'b1);
        check("t6.fresh_result", OutResult, 32'hC);
        check("t6.fresh_flags", OutFlags, 4'b0000);
        step();
        check("t6.single", OutValid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
